if_id_queue: RTL and testbench



---
 rtl/if_id_pkg.sv | 27 ++
 rtl/if_id_queue_storage.sv | 28 ++
 rtl/if_id_queue.sv | 116 +++++++++++
 tb/tb_if_id_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID instruction queue.
// Optional predecode flag storage is enabled with IFQ_PREDECODE_EN.
package if_id_pkg;

  localparam int unsigned IFQ_XLEN = 32;

  // Canonical RISC-V NOP (addi x0, x0, 0) shown to decode when the queue is empty.
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [IFQ_XLEN-1:0] pc;
    logic [IFQ_XLEN-1:0] instr;
`ifdef IFQ_PREDECODE_EN
    logic                is_ctrl;
`endif
  } ifq_entry_t;

  // True when the opcode redirects control flow (branch, jal, jalr).
  function automatic logic is_ctrl_op(input logic [6:0] opcode);
    return (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
  endfunction

endpackage

// File: rtl/if_id_queue_storage.sv
// Entry array for the IF/ID queue: one synchronous write port, one
// combinational read port. Data carries no reset; validity is tracked outside.
module ifq_storage
  import if_id_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  ifq_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output ifq_entry_t    rdata
);

  ifq_entry_t mem [DEPTH];

  // Write the addressed entry when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: buffers {pc, instr} from fetch so fetch can keep
// running while decode stalls; flush discards everything.
// Build option: IFQ_PREDECODE_EN adds out_is_ctrl (control-flow predecode bit).
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = IFQ_XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
`ifdef IFQ_PREDECODE_EN
  output logic                     out_is_ctrl,
`endif
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic       push, pop;
  ifq_entry_t wdata, rdata;

  // Handshakes depend only on registered occupancy, never on the other side.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state for pointers and occupancy; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth: natural pointer overflow is the modulo wrap.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Pack the incoming fetch word, predecoding control flow when enabled.
  always_comb begin
    wdata       = '0;
    wdata.pc    = in_pc;
    wdata.instr = in_instr;
`ifdef IFQ_PREDECODE_EN
    wdata.is_ctrl = is_ctrl_op(in_instr[6:0]);
`endif
  end

  ifq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  // Head entry toward decode; empty queue presents pc 0 and a NOP.
  always_comb begin
    out_pc    = '0;
    out_instr = NOP;
`ifdef IFQ_PREDECODE_EN
    out_is_ctrl = 1'b0;
`endif
    if (out_valid) begin
      out_pc    = rdata.pc;
      out_instr = rdata.instr;
`ifdef IFQ_PREDECODE_EN
      out_is_ctrl = rdata.is_ctrl;
`endif
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue against a queue-based reference model.
// Compile with IFQ_PREDECODE_EN to also check out_is_ctrl.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            flush;
  logic [2:0]      count;
`ifdef IFQ_PREDECODE_EN
  logic            out_is_ctrl;
`endif

  if_id_queue #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
`ifdef IFQ_PREDECODE_EN
    .out_is_ctrl (out_is_ctrl),
`endif
    .flush       (flush),
    .count       (count)
  );

  always #5 clk = ~clk;

  // Reference model: a bounded FIFO of {pc, instr}.
  logic [31:0] m_pc[$];
  logic [31:0] m_instr[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic ref_ctrl(input logic [31:0] instr);
    logic [6:0] op;
    op = instr[6:0];
    return (op == 7'h63) || (op == 7'h6f) || (op == 7'h67);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's current state.
  task automatic check_outputs();
    int unsigned sz;
    sz = m_pc.size();
    chk("count", 64'(count), 64'(sz));
    chk("in_ready", 64'(in_ready), 64'(sz != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(sz != 0));
    chk("out_pc", 64'(out_pc), (sz != 0) ? 64'(m_pc[0]) : 64'h0);
    chk("out_instr", 64'(out_instr), (sz != 0) ? 64'(m_instr[0]) : 64'(NOP_W));
`ifdef IFQ_PREDECODE_EN
    chk("out_is_ctrl", 64'(out_is_ctrl), (sz != 0) ? 64'(ref_ctrl(m_instr[0])) : 64'h0);
`endif
  endtask

  // One clock: drive, check pre-edge state, advance model at the edge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic ordy, input logic fl);
    logic can_push, do_pop;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_outputs();
    can_push = v && (m_pc.size() != DEPTH);
    do_pop   = ordy && (m_pc.size() != 0);
    @(posedge clk);
    if (fl) begin
      m_pc.delete();
      m_instr.delete();
    end else begin
      if (do_pop) begin
        void'(m_pc.pop_front());
        void'(m_instr.pop_front());
      end
      if (can_push) begin
        m_pc.push_back(pc);
        m_instr.push_back(instr);
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] rpc, rins;
    logic [6:0]  ops [4];
    ops[0] = 7'h63; ops[1] = 7'h6f; ops[2] = 7'h67; ops[3] = 7'h13;

    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
    #2;
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_out_instr", 64'(out_instr), 64'(NOP_W));
    chk("rst_out_pc", 64'(out_pc), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Push three with decode stalled.
    cycle(1'b1, 32'h00, 32'h00500093, 1'b0, 1'b0);
    cycle(1'b1, 32'h04, 32'h00a00113, 1'b0, 1'b0);
    cycle(1'b1, 32'h08, 32'h002081b3, 1'b0, 1'b0);
    check_outputs();
    chk("three_count", 64'(count), 64'h3);
    chk("three_out_pc", 64'(out_pc), 64'h0);

    // Fill, then push while full with a simultaneous pop: only the pop happens.
    cycle(1'b1, 32'h0c, 32'h00000013, 1'b0, 1'b0);
    chk("full_in_ready", 64'(in_ready), 64'h0);
    cycle(1'b1, 32'h10, 32'h11111113, 1'b1, 1'b0);
    chk("full_pop_count", 64'(count), 64'h3);
    drain();

    // Streaming push+pop across pointer wraps.
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'(i * 4), 32'h1000_0013 + 32'(i), 1'b1, 1'b0);
    chk("stream_count", 64'(count), 64'h1);
    drain();

    // Flush beats same-cycle push and pop.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h20 + 32'(i * 4), 32'h2000_0013, 1'b0, 1'b0);
    cycle(1'b1, 32'h40, 32'h4000_0013, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'h0);
    chk("flush_out_valid", 64'(out_valid), 64'h0);
    chk("flush_out_instr", 64'(out_instr), 64'(NOP_W));
    chk("flush_in_ready", 64'(in_ready), 64'h1);
    drain();

    // Asynchronous reset with two entries queued.
    cycle(1'b1, 32'h50, 32'h5000_0013, 1'b0, 1'b0);
    cycle(1'b1, 32'h54, 32'h5400_0013, 1'b0, 1'b0);
    in_valid = 1'b0;
    chk("pre_arst_count", 64'(count), 64'h2);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'h0);
    chk("arst_count", 64'(count), 64'h0);
    m_pc.delete();
    m_instr.delete();
    #2 rst = 1'b0;
    #1;
    chk("post_arst_in_ready", 64'(in_ready), 64'h1);
    check_outputs();

`ifdef IFQ_PREDECODE_EN
    cycle(1'b1, 32'h60, 32'hfe0008e3, 1'b0, 1'b0);
    cycle(1'b1, 32'h64, 32'h00000013, 1'b0, 1'b0);
    chk("beq_is_ctrl", 64'(out_is_ctrl), 64'h1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("nop_is_ctrl", 64'(out_is_ctrl), 64'h0);
    drain();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rpc  = {$urandom()} & 32'hffff_fffc;
      rins = {$urandom()};
      rins[6:0] = ops[$urandom_range(0, 3)];
      cycle($urandom_range(0, 9) < 7, rpc, rins, $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0);
    end
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
